cpu_sequencer: RTL

- Multi-cycle control FSM that steps the 16-bit datapath through fetch, decode, execute, memory and writeback.
- Consumes the static per-instruction control signals from the instruction-decode logic. Issues instruction and data memory requests with req/ack handshakes.
- Produces one-cycle enables for IR load, register-file write and PC update.
- Handles halt and memory timeout.

---
 rtl/cpu_sequencer_pkg.sv | 22 ++
 rtl/cpu_sequencer_timeout_counter.sv | 41 ++++
 rtl/cpu_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the multi-cycle CPU sequencer: state encodings and
// the default memory-wait limit used by any memory master in the core.
package cpu_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_ERROR  = 3'd6
   } seq_state_e;

   localparam int unsigned DEFAULT_MEM_TIMEOUT = 255;
   localparam int unsigned TIMEOUT_W           = 16;

   function automatic logic isMemWait(input seq_state_e s);
      return (s == ST_FETCH) || (s == ST_MEM);
   endfunction

endpackage

// File: rtl/cpu_sequencer_timeout_counter.sv
// Wait-cycle counter shared by the instruction and data memory handshakes;
// expired_o flags the LIMIT-th consecutive cycle without an ack.
module seq_timeout_counter
   import cpu_sequencer_pkg::*;
#(
   parameter int unsigned LIMIT = DEFAULT_MEM_TIMEOUT,
   parameter int unsigned W     = TIMEOUT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q holds the waits already seen, so this cycle is the LIMIT-th one
   assign expired_o = inc_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM stepping the 16-bit datapath through
// fetch/decode/execute/memory/writeback with req/ack memory handshakes.
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   input  logic             ctl_regwrite,
   input  logic             ctl_memread,
   input  logic             ctl_memwrite,
   input  logic             ctl_hlt,
   output logic             imem_req,
   output logic             ir_load,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             reg_we,
   output logic             pc_en,
   output logic             halted,
   output logic             error,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired
);

   seq_state_e       state_q;
   seq_state_e       state_d;
   logic [CNT_W-1:0] retired_q;
   logic [CNT_W-1:0] retired_d;
   logic             inWait;
   logic             waitAck;
   logic             expired;

   // Only the ack belonging to the current wait state counts
   assign inWait  = isMemWait(state_q);
   assign waitAck = ((state_q == ST_FETCH) && imem_ack) ||
                    ((state_q == ST_MEM)   && dmem_ack);

   seq_timeout_counter #(
      .LIMIT (MEM_TIMEOUT),
      .W     (TIMEOUT_W)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (!inWait || waitAck),
      .inc_i     (inWait && !waitAck),
      .expired_o (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               state_d = ST_DECODE;
            end else if (expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_DECODE: state_d = ctl_hlt ? ST_HALT : ST_EXEC;
         ST_EXEC:   state_d = (ctl_memread || ctl_memwrite) ? ST_MEM : ST_WB;
         ST_MEM: begin
            if (dmem_ack) begin
               state_d = ST_WB;
            end else if (expired) begin
               state_d = ST_ERROR;
            end
         end
         ST_WB:     state_d = ST_FETCH;
         ST_HALT:   state_d = ST_HALT;
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      retired_d = retired_q;
      if (state_q == ST_WB) begin
         retired_d = retired_q + 1'b1;
      end
   end

   // Requests are masked by rst so a reset drops them without waiting for a clock
   always_comb begin
      imem_req = 1'b0;
      ir_load  = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      reg_we   = 1'b0;
      pc_en    = 1'b0;
      halted   = 1'b0;
      error    = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               imem_req = 1'b1;
               ir_load  = imem_ack;
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = ctl_memwrite;
            end
            ST_WB: begin
               pc_en  = 1'b1;
               reg_we = ctl_regwrite && !ctl_memwrite;
            end
            ST_HALT:  halted = 1'b1;
            ST_ERROR: error  = 1'b1;
            default: begin
            end
         endcase
      end
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule
